pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline stage register. It carries a control field and a data payload between two processor pipeline stages (e.g. EX→MEM) with a valid/ready handshake, flush and bubble insertion. It is the generic successor to the fixed-width stage latches and is instantiated once per stage boundary. The control field is forced to zero on bubbles, so a bubble never triggers a register write or a memory access.

---
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready handshake, flush and status bundle for one pipeline stage boundary
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter int CNT_W  = 16
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  modport slave (
    input  flush_i, in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_ctrl_o, out_data_o, stall_cnt_o
  );
  modport master (
    output flush_i, in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic stage register with flush, bubble ctrl gating and stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid version with a registered in_ready_o.
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter int CNT_W  = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  pipe_stage_reg_if.slave bus
);
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_valid;
  logic              w_ready;
  logic              w_acc;
  logic              w_dlv;
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t            r_state;
  logic              r_ready;
  logic [CTRL_W-1:0] r_sk_ctrl;
  logic [DATA_W-1:0] r_sk_data;
  assign w_valid = r_state != EMPTY;
  assign w_ready = r_ready;
  assign w_acc   = bus.in_valid_i & w_ready;
  assign w_dlv   = w_valid & bus.out_ready_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= EMPTY;
      r_ready   <= 1'b1;
      r_ctrl    <= '0;
      r_data    <= '0;
      r_sk_ctrl <= '0;
      r_sk_data <= '0;
    end else if (bus.flush_i) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: if (w_acc) begin
          r_state <= ONE;
          r_ctrl  <= bus.in_ctrl_i;
          r_data  <= bus.in_data_i;
        end
        ONE: if (w_acc && w_dlv) begin
          r_ctrl <= bus.in_ctrl_i;
          r_data <= bus.in_data_i;
        end else if (w_acc) begin
          r_state   <= TWO;
          r_ready   <= 1'b0;
          r_sk_ctrl <= bus.in_ctrl_i;
          r_sk_data <= bus.in_data_i;
        end else if (w_dlv) begin
          r_state <= EMPTY;
        end
        default: if (w_dlv) begin
          r_state <= ONE;
          r_ready <= 1'b1;
          r_ctrl  <= r_sk_ctrl;
          r_data  <= r_sk_data;
        end
      endcase
    end
  end
`else
  typedef enum logic {EMPTY, FULL} state_t;
  state_t r_state;
  assign w_valid = r_state == FULL;
  assign w_ready = (r_state == EMPTY) | bus.out_ready_i;
  assign w_acc   = bus.in_valid_i & w_ready;
  assign w_dlv   = w_valid & bus.out_ready_i;
  // A full stage only refuses input when nothing leaves this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (bus.flush_i) begin
      r_state <= EMPTY;
    end else if (w_acc) begin
      r_state <= FULL;
      r_ctrl  <= bus.in_ctrl_i;
      r_data  <= bus.in_data_i;
    end else if (w_dlv) begin
      r_state <= EMPTY;
    end
  end
`endif
  // Flush leaves the stall count alone; it only tracks downstream backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_cnt <= '0;
    else if (w_valid && !bus.out_ready_i && !(&r_cnt))
      r_cnt <= r_cnt + CNT_W'(1);
  end
  assign bus.in_ready_o  = w_ready;
  assign bus.out_valid_o = w_valid;
  assign bus.out_ctrl_o  = w_valid ? r_ctrl : '0;
  assign bus.out_data_o  = r_data;
  assign bus.stall_cnt_o = r_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench covering reset, streaming, backpressure, flush, bubble gating and saturation
module tb_pipe_stage_reg;
  localparam int CW = 4;
  localparam int DW = 69;
  localparam int NW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  logic acc, dlv, b_acc;
  logic [CW+DW-1:0] q[$];
  logic [CW+DW-1:0] exp_beat;
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) bus ();
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bus.in_valid_i = v;
    bus.in_ctrl_i  = c;
    bus.in_data_i  = d;
  endtask
  // Settle, record the handshakes of the coming edge in the scoreboard, then move to the next negedge.
  task automatic tick();
    #1;
    acc = bus.in_valid_i & bus.in_ready_o;
    dlv = bus.out_valid_o & bus.out_ready_i;
    if (!bus.out_valid_o) chk("ctrl_gate", 128'(bus.out_ctrl_o), 128'(0));
    if (rst) q.delete();
    else begin
      if (dlv) begin
        chk("sb_nonempty", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) begin
          exp_beat = q.pop_front();
          chk("sb_beat", 128'({bus.out_ctrl_o, bus.out_data_o}), 128'(exp_beat));
        end
      end
      if (bus.flush_i) q.delete();
      else if (acc) q.push_back({bus.in_ctrl_i, bus.in_data_i});
    end
    @(negedge clk);
  endtask
  initial begin
    bus.flush_i = 1'b0;
    bus.out_ready_i = 1'b0;
    drive(1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      bus.flush_i = 1'($urandom);
      bus.out_ready_i = 1'($urandom);
      drive(1'($urandom), CW'($urandom), DW'({$urandom, $urandom, $urandom}));
      tick();
    end
    chk("rst_valid", 128'(bus.out_valid_o), 128'(0));
    chk("rst_ctrl", 128'(bus.out_ctrl_o), 128'(0));
    chk("rst_data", 128'(bus.out_data_o), 128'(0));
    chk("rst_cnt", 128'(bus.stall_cnt_o), 128'(0));
    rst = 1'b0;
    bus.flush_i = 1'b0;
    bus.out_ready_i = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("rst_ready", 128'(bus.in_ready_o), 128'(1));
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'hF, DW'(i));
      tick();
      chk("stream_acc", 128'(acc), 128'(1));
      chk("stream_valid", 128'(bus.out_valid_o), 128'(1));
      chk("stream_data", 128'(bus.out_data_o), 128'(i));
    end
    drive(1'b0, '0, '0);
    tick();
    chk("stream_drain", 128'(bus.out_valid_o), 128'(0));
    chk("stream_cnt", 128'(bus.stall_cnt_o), 128'(0));
    bus.out_ready_i = 1'b0;
    drive(1'b1, 4'h3, DW'('hA));
    tick();
    chk("bp_load", 128'(acc), 128'(1));
    drive(1'b1, 4'h5, DW'('hB));
    b_acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (acc) begin
        b_acc = 1'b1;
        bus.in_valid_i = 1'b0;
      end
    end
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_skid_acc", 128'(b_acc), 128'(1));
`else
    chk("bp_base_refuse", 128'(b_acc), 128'(0));
`endif
    #1;
    chk("bp_ready", 128'(bus.in_ready_o), 128'(0));
    chk("bp_hold", 128'(bus.out_data_o), 128'('hA));
    chk("bp_cnt", 128'(bus.stall_cnt_o), 128'(3));
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    tick();
    if (acc) bus.in_valid_i = 1'b0;
    chk("bp_rel_valid", 128'(bus.out_valid_o), 128'(1));
    chk("bp_rel_data", 128'(bus.out_data_o), 128'('hB));
    bus.in_valid_i = 1'b0;
    tick();
    chk("bp_empty", 128'(bus.out_valid_o), 128'(0));
    drive(1'b1, 4'b1011, DW'('h55));
    tick();
    chk("bub_ctrl_on", 128'(bus.out_ctrl_o), 128'(4'b1011));
    drive(1'b0, '0, '0);
    tick();
    chk("bub_ctrl_off", 128'(bus.out_ctrl_o), 128'(0));
    chk("bub_data_hold", 128'(bus.out_data_o), 128'('h55));
    bus.out_ready_i = 1'b0;
    drive(1'b1, 4'h1, DW'('hC));
    tick();
    drive(1'b1, 4'h2, DW'('hD));
    tick();
    bus.flush_i = 1'b1;
    drive(1'b1, 4'h4, DW'('hE));
    tick();
    bus.flush_i = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_valid", 128'(bus.out_valid_o), 128'(0));
    chk("fl_ctrl", 128'(bus.out_ctrl_o), 128'(0));
    #1;
    chk("fl_ready", 128'(bus.in_ready_o), 128'(1));
    @(negedge clk);
    bus.flush_i = 1'b1;
    drive(1'b1, 4'h6, DW'('hF));
    tick();
    chk("fl_same_acc", 128'(acc), 128'(1));
    bus.flush_i = 1'b0;
    drive(1'b0, '0, '0);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("fl_nothing", 128'(bus.out_valid_o), 128'(0));
    bus.out_ready_i = 1'b0;
    drive(1'b1, 4'h7, DW'('h77));
    tick();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 128'(bus.stall_cnt_o), 128'(15));
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("sat_flush_cnt", 128'(bus.stall_cnt_o), 128'(15));
    chk("sat_flush_valid", 128'(bus.out_valid_o), 128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_rst_cnt", 128'(bus.stall_cnt_o), 128'(0));
    chk("sb_drained", 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
